udp_payload_frame_fifo: RTL and testbench
=========================================

Name: udp_payload_frame_fifo

Overview:
- Store-and-forward packet FIFO for 8-bit UDP payload streams. It sits between the UDP stack's payload output and the downstream application or echo path.
- Accepts a whole frame and releases it only once its tlast arrives with tuser clear.
- Frames flagged bad (tuser) or overflowing capacity are discarded entirely, so downstream never sees partial or corrupt payloads.

Parameters:
- DEPTH, 2048, storage entries (bytes); power of two, ≥16.
- CNT_W, 16, width of status counters.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  8  payload byte in.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input ready.
- s_axis_tlast  input  1  last byte of frame.
- s_axis_tuser  input  1  frame error flag; honoured on any beat.
- m_axis_tdata  output  8  payload byte out.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tready  input  1  output ready.
- m_axis_tlast  output  1  last byte of frame.
- m_axis_tuser  output  1  always 0; only good frames are emitted.
- frame_count  output  $clog2(DEPTH)+1  committed frames not yet fully read.
- drop_count  output  CNT_W  frames discarded, saturating.
- drop_pulse  output  1  one-cycle pulse per discarded frame.

Behaviour:
- Reset (reset=0, async): all pointers 0; state NORMAL. Outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_count=0, drop_count=0, drop_pulse=0.
- After reset deasserts: s_axis_tready=1 from the first clock edge. Input is never back-pressured; overflow is handled by dropping.
- Storage: DEPTH x 9-bit entries {tlast, tdata}. Pointers wr_ptr, wr_commit, rd_ptr are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); the MSB distinguishes full from empty on wrap.
- Write FSM:
  - NORMAL: each accepted beat writes at wr_ptr and increments wr_ptr.
  - Error latch: tuser=1 on any beat sets a sticky err flag.
  - Overflow: a beat arriving when wr_ptr−rd_ptr==DEPTH is not written; the block enters DROP.
  - NORMAL + tlast, err=0: wr_commit←wr_ptr+1 and frame_count increments.
  - NORMAL + tlast, err=1: wr_ptr←wr_commit (rollback), drop_pulse, drop_count+1, err cleared.
  - DROP: beats accepted and discarded. On tlast: wr_ptr←wr_commit, drop_pulse, drop_count+1, return to NORMAL, err cleared.
- Frames longer than DEPTH are always dropped.
- Read path:
  - Read is permitted when rd_ptr≠wr_commit.
  - The synchronous RAM read feeds a one-entry output register, with a prefetch/skid so throughput is 1 byte/cycle under continuous m_axis_tready.
  - Latency: with the output idle, m_axis_tvalid rises exactly 2 cycles after the accepting edge of a good tlast.
  - m_axis_tdata and m_axis_tlast are stable while tvalid=1 and tready=0.
  - frame_count decrements on the output handshake with m_axis_tlast=1.
- Simultaneous commit and final-beat read in the same cycle: frame_count is net unchanged.
- Rollback never touches rd_ptr or the committed region.
- Reset mid-frame discards everything, including committed and partially read frames.
- drop_count saturates at all-ones; drop_pulse still fires when saturated.

Decomposition:
- Package udp_fifo_pkg:
  - typedef fifo_entry_t (packed {last, data[7:0]}).
  - enum wr_state_t {NORMAL, DROP}.
  - localparam function for ADDR_W.
- Sub-module udp_fifo_ram: simple dual-port RAM, 1 write/1 read port, registered read, no reset on the array.

Test Plan:
- Single good frame of 10 bytes 0x00..0x09, m_axis_tready=1 → identical 10 bytes out; tlast on 0x09; tvalid rises 2 cycles after input tlast; frame_count 1→0.
- 64-byte frame with tuser=1 on byte 20, then a good 4-byte frame → only the 4-byte frame emitted; drop_count=1; one drop_pulse; no bytes of the bad frame appear.
- DEPTH=16, m_axis_tready=0: 10-byte good frame, then 10-byte frame → second frame dropped (drop_count=1); releasing tready yields exactly the first 10 bytes.
- DEPTH=16: 20-byte frame → dropped; the following good 16-byte frame fills the FIFO exactly, is accepted, and is read out intact (full boundary, pointer wrap).
- Random tready (50%), 100 back-to-back good frames of lengths 1..64 → output byte-exact vs scoreboard; frame_count never exceeds stored frames.
- Assert reset mid-write of frame 2 while frame 1 is half read → all outputs at reset values; post-reset frame transfers correctly.

Source files
------------

// File: rtl/udp_fifo_pkg.sv
// Shared types for the UDP payload store-and-forward FIFO.
package udp_fifo_pkg;

    // One storage word: payload byte plus its end-of-frame marker.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        DROP   = 1'b1
    } wr_state_t;

    // Address width of the storage array for a given entry count.
    function automatic int addr_w_f(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/udp_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, array not reset.
module udp_fifo_ram
    import udp_fifo_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  fifo_entry_t       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output fifo_entry_t       rd_data
);

    fifo_entry_t mem [2**ADDR_W];
    fifo_entry_t rd_data_q;

    // Array write and registered read; read data holds when rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_payload_frame_fifo.sv
// Store-and-forward frame FIFO for 8-bit UDP payload. Frames become visible to
// the reader only when committed by a clean tlast; bad or overflowing frames
// are rolled back to the last commit point.
//
//   state  | meaning
//   NORMAL | writing beats of the current frame into storage
//   DROP   | frame overflowed; swallow beats until its tlast, then roll back
module udp_payload_frame_fifo
    import udp_fifo_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [$clog2(DEPTH):0]   frame_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     drop_pulse
);

    localparam int ADDR_W = addr_w_f(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    wr_state_t          wr_state_q, wr_state_d;
    logic               err_q, err_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               in_ready_q, in_ready_d;
    logic               pend_q, pend_d;
    logic               out_valid_q, out_valid_d;
    logic               skid_valid_q, skid_valid_d;
    fifo_entry_t        out_q, out_d;
    fifo_entry_t        skid_q, skid_d;
    logic [PTR_W-1:0]   frame_count_q, frame_count_d;
    logic [CNT_W-1:0]   drop_count_q, drop_count_d;
    logic               drop_pulse_q, drop_pulse_d;

    logic               beat, full, ram_we, commit, drop, pop, pop_last, issue;
    logic [PTR_W-1:0]   fill;
    logic [1:0]         occ;
    fifo_entry_t        wr_entry, ram_rd_data;

    assign wr_entry = '{last: s_axis_tlast, data: s_axis_tdata};

    udp_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_entry),
        .rd_en   (issue),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // Write FSM: store beats, commit on clean tlast, roll back on error/overflow.
    always_comb begin
        beat        = s_axis_tvalid & in_ready_q;
        fill        = wr_ptr_q - rd_ptr_q;
        full        = (fill == PTR_FULL);
        in_ready_d  = 1'b1;
        wr_state_d  = wr_state_q;
        err_d       = err_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        ram_we      = 1'b0;
        commit      = 1'b0;
        drop        = 1'b0;
        case (wr_state_q)
            NORMAL: begin
                if (beat) begin
                    if (full) begin
                        // Overflowing beat is never stored; a tlast here ends the frame at once.
                        if (s_axis_tlast) begin
                            drop     = 1'b1;
                            wr_ptr_d = wr_commit_q;
                            err_d    = 1'b0;
                        end else begin
                            wr_state_d = DROP;
                        end
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_axis_tlast) begin
                            if (err_q | s_axis_tuser) begin
                                drop     = 1'b1;
                                wr_ptr_d = wr_commit_q;
                                err_d    = 1'b0;
                            end else begin
                                commit      = 1'b1;
                                wr_commit_d = wr_ptr_q + PTR_ONE;
                            end
                        end else begin
                            err_d = err_q | s_axis_tuser;
                        end
                    end
                end
            end
            DROP: begin
                if (beat && s_axis_tlast) begin
                    drop       = 1'b1;
                    wr_ptr_d   = wr_commit_q;
                    err_d      = 1'b0;
                    wr_state_d = NORMAL;
                end
            end
            default: wr_state_d = NORMAL;
        endcase
    end

    // Read path: prefetch from RAM into an output register backed by a skid slot.
    // A read is issued only if the byte it returns is guaranteed a free slot.
    always_comb begin
        pop          = out_valid_q & m_axis_tready;
        pop_last     = pop & out_q.last;
        occ          = {1'b0, pend_q} + {1'b0, out_valid_q} + {1'b0, skid_valid_q};
        issue        = (rd_ptr_q != wr_commit_q) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
        rd_ptr_d     = issue ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        pend_d       = issue;
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = pend_q;
                skid_d       = pend_q ? ram_rd_data : skid_q;
            end else if (pend_q) begin
                out_valid_d = 1'b1;
                out_d       = ram_rd_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (pend_q) begin
            skid_valid_d = 1'b1;
            skid_d       = ram_rd_data;
        end
    end

    // Status: frame count nets commit against last-byte handshake; drop counter saturates.
    always_comb begin
        frame_count_d = frame_count_q;
        if (commit && !pop_last) begin
            frame_count_d = frame_count_q + PTR_ONE;
        end else if (!commit && pop_last) begin
            frame_count_d = frame_count_q - PTR_ONE;
        end
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
        drop_pulse_d = drop;
    end

    // State registers; reset discards all stored and in-flight data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state_q    <= NORMAL;
            err_q         <= 1'b0;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            rd_ptr_q      <= '0;
            in_ready_q    <= 1'b0;
            pend_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            out_q         <= '0;
            skid_q        <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            drop_pulse_q  <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            err_q         <= err_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            rd_ptr_q      <= rd_ptr_d;
            in_ready_q    <= in_ready_d;
            pend_q        <= pend_d;
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            out_q         <= out_d;
            skid_q        <= skid_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            drop_pulse_q  <= drop_pulse_d;
        end
    end

    assign s_axis_tready = in_ready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tuser  = 1'b0;
    assign frame_count   = frame_count_q;
    assign drop_count    = drop_count_q;
    assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_udp_payload_frame_fifo.sv
// Bench for udp_payload_frame_fifo: a large instance for stream tests and a
// DEPTH=16 instance for capacity tests; one is selected at a time.
module tb_udp_payload_frame_fifo;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sel;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_user;
    logic       m_rdy, rdy_fixed, rand_rdy;

    logic        b_sready, b_mvalid, b_mlast, b_muser, b_dp;
    logic [7:0]  b_mdata;
    logic [11:0] b_fc;
    logic [15:0] b_dc;
    logic        s_sready, s_mvalid, s_mlast, s_muser, s_dp;
    logic [7:0]  s_mdata;
    logic [4:0]  s_fc;
    logic [15:0] s_dc;

    udp_payload_frame_fifo #(.DEPTH(2048), .CNT_W(16)) dut_big (
        .clk(clk), .reset(reset),
        .s_axis_tdata(in_data), .s_axis_tvalid(in_valid & ~sel), .s_axis_tready(b_sready),
        .s_axis_tlast(in_last), .s_axis_tuser(in_user),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(m_rdy & ~sel),
        .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser),
        .frame_count(b_fc), .drop_count(b_dc), .drop_pulse(b_dp)
    );

    udp_payload_frame_fifo #(.DEPTH(16), .CNT_W(16)) dut_small (
        .clk(clk), .reset(reset),
        .s_axis_tdata(in_data), .s_axis_tvalid(in_valid & sel), .s_axis_tready(s_sready),
        .s_axis_tlast(in_last), .s_axis_tuser(in_user),
        .m_axis_tdata(s_mdata), .m_axis_tvalid(s_mvalid), .m_axis_tready(m_rdy & sel),
        .m_axis_tlast(s_mlast), .m_axis_tuser(s_muser),
        .frame_count(s_fc), .drop_count(s_dc), .drop_pulse(s_dp)
    );

    logic        o_sready, o_valid, o_last, o_user, o_dp;
    logic [7:0]  o_data;
    logic [11:0] o_fc;
    logic [15:0] o_dc;
    assign o_sready = sel ? s_sready : b_sready;
    assign o_valid  = sel ? s_mvalid : b_mvalid;
    assign o_last   = sel ? s_mlast  : b_mlast;
    assign o_user   = sel ? s_muser  : b_muser;
    assign o_dp     = sel ? s_dp     : b_dp;
    assign o_data   = sel ? s_mdata  : b_mdata;
    assign o_fc     = sel ? {7'b0, s_fc} : b_fc;
    assign o_dc     = sel ? s_dc     : b_dc;

    int vec = 0;
    int miscmp = 0;

    // Output monitor: records every handshaken byte and every drop pulse.
    logic [8:0] rx_q[$];
    int rx_frames = 0;
    int dp_seen = 0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (o_valid && m_rdy) begin
                rx_q.push_back({o_last, o_data});
                if (o_last) rx_frames++;
            end
            if (o_dp) dp_seen++;
        end
    end

    // Output ready driver: fixed level or 50% random per cycle.
    initial begin
        m_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: the expected output stream holds good frames only.
    logic [8:0] exp_q[$];
    int exp_dc_big = 0;
    int exp_dc_small = 0;

    function automatic bq_t rand_frame(input int len);
        bq_t d;
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        return d;
    endfunction

    task automatic expect_frame(input bq_t d);
        for (int i = 0; i < d.size(); i++) exp_q.push_back({(i == d.size() - 1), d[i]});
    endtask

    function automatic int first_diff(input int base);
        if (rx_q.size() - base != exp_q.size()) return -2;
        for (int i = 0; i < exp_q.size(); i++)
            if (rx_q[base + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic send_frame(input bq_t d, input int bad_at);
        for (int i = 0; i < d.size(); i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            in_last  = (i == d.size() - 1);
            in_user  = (i == bad_at);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (rx_q.size() >= n);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vec++;
            if ({o_sready, o_valid, o_last, o_user, o_dp, o_data, o_fc, o_dc} !== '0) begin
                miscmp++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b vld=%b last=%b dp=%b data=%h fc=%0d dc=%0d expected all zero",
                         s, o_sready, o_valid, o_last, o_dp, o_data, o_fc, o_dc);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vec++;
            if (o_sready !== 1'b1) begin
                miscmp++;
                $display("FAIL ready_after_reset dut%0d: got %b expected 1", s, o_sready);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_single_frame();
        bq_t d;
        int base, fd;
        bit ok;
        sel = 1'b0;
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        base = rx_q.size();
        exp_q.delete();
        for (int i = 0; i < 10; i++) d.push_back(8'(i));
        expect_frame(d);
        send_frame(d, -1);
        vec++;
        if (o_fc !== 12'd1) begin
            miscmp++;
            $display("FAIL single_fc_commit: got %0d expected 1", o_fc);
        end
        vec++;
        if (o_valid !== 1'b0) begin
            miscmp++;
            $display("FAIL single_latency_e0: tvalid got %b expected 0", o_valid);
        end
        @(posedge clk);
        #1;
        vec++;
        if (o_valid !== 1'b0) begin
            miscmp++;
            $display("FAIL single_latency_e1: tvalid got %b expected 0", o_valid);
        end
        @(posedge clk);
        #1;
        vec++;
        if (o_valid !== 1'b1) begin
            miscmp++;
            $display("FAIL single_latency_e2: tvalid got %b expected 1", o_valid);
        end
        wait_rx(base + 10, 100, ok);
        vec++;
        if (!ok) begin
            miscmp++;
            $display("FAIL single_timeout: got %0d bytes expected 10", rx_q.size() - base);
        end
        fd = first_diff(base);
        vec++;
        if (fd != -1) begin
            miscmp++;
            $display("FAIL single_data: got %0d bytes (first bad index %0d) expected %0d bytes", rx_q.size() - base, fd, exp_q.size());
        end
        vec++;
        if (o_fc !== 12'd0) begin
            miscmp++;
            $display("FAIL single_fc_drain: got %0d expected 0", o_fc);
        end
    endtask

    task automatic test_bad_frame();
        bq_t d1, d2;
        int base, dp_base, fd;
        bit ok;
        sel = 1'b0;
        rdy_fixed = 1'b1;
        base = rx_q.size();
        dp_base = dp_seen;
        exp_q.delete();
        d1 = rand_frame(64);
        d2 = rand_frame(4);
        expect_frame(d2);
        exp_dc_big++;
        send_frame(d1, 20);
        send_frame(d2, -1);
        wait_rx(base + 4, 200, ok);
        vec++;
        if (!ok) begin
            miscmp++;
            $display("FAIL bad_timeout: got %0d bytes expected 4", rx_q.size() - base);
        end
        fd = first_diff(base);
        vec++;
        if (fd != -1) begin
            miscmp++;
            $display("FAIL bad_data: got %0d bytes (first bad index %0d) expected %0d bytes", rx_q.size() - base, fd, exp_q.size());
        end
        vec++;
        if (o_dc !== 16'(exp_dc_big)) begin
            miscmp++;
            $display("FAIL bad_drop_count: got %0d expected %0d", o_dc, exp_dc_big);
        end
        vec++;
        if (dp_seen - dp_base != 1) begin
            miscmp++;
            $display("FAIL bad_drop_pulse: got %0d pulses expected 1", dp_seen - dp_base);
        end
    endtask

    task automatic test_back_to_back();
        bq_t d;
        int base, fr_base, good, fd;
        bit ok;
        sel = 1'b0;
        rand_rdy = 1'b1;
        base = rx_q.size();
        fr_base = rx_frames;
        good = 0;
        exp_q.delete();
        for (int f = 0; f < 100; f++) begin
            d = rand_frame($urandom_range(1, 64));
            expect_frame(d);
            send_frame(d, -1);
            good++;
            vec++;
            if (o_fc !== 12'(good - (rx_frames - fr_base))) begin
                miscmp++;
                $display("FAIL b2b_frame_count f%0d: got %0d expected %0d", f, o_fc, good - (rx_frames - fr_base));
            end
            if (f % 20 == 19) begin
                wait_rx(base + exp_q.size(), 4000, ok);
                vec++;
                if (!ok) begin
                    miscmp++;
                    $display("FAIL b2b_timeout f%0d: got %0d bytes expected %0d", f, rx_q.size() - base, exp_q.size());
                end
            end
        end
        rand_rdy = 1'b0;
        rdy_fixed = 1'b1;
        wait_rx(base + exp_q.size(), 200, ok);
        fd = first_diff(base);
        vec++;
        if (fd != -1) begin
            miscmp++;
            $display("FAIL b2b_data: got %0d bytes (first bad index %0d) expected %0d bytes", rx_q.size() - base, fd, exp_q.size());
        end
        vec++;
        if (o_dc !== 16'(exp_dc_big) || o_fc !== 12'd0) begin
            miscmp++;
            $display("FAIL b2b_status: got dc=%0d fc=%0d expected dc=%0d fc=0", o_dc, o_fc, exp_dc_big);
        end
    endtask

    task automatic test_overflow();
        bq_t a, b;
        int base, dp_base, fd;
        bit ok;
        sel = 1'b1;
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = rx_q.size();
        dp_base = dp_seen;
        exp_q.delete();
        a = rand_frame(10);
        b = rand_frame(10);
        expect_frame(a);
        exp_dc_small++;
        send_frame(a, -1);
        send_frame(b, -1);
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (o_fc !== 12'd1 || o_dc !== 16'(exp_dc_small)) begin
            miscmp++;
            $display("FAIL ovf_status: got fc=%0d dc=%0d expected fc=1 dc=%0d", o_fc, o_dc, exp_dc_small);
        end
        vec++;
        if (dp_seen - dp_base != 1) begin
            miscmp++;
            $display("FAIL ovf_drop_pulse: got %0d pulses expected 1", dp_seen - dp_base);
        end
        rdy_fixed = 1'b1;
        wait_rx(base + 10, 100, ok);
        fd = first_diff(base);
        vec++;
        if (!ok || fd != -1) begin
            miscmp++;
            $display("FAIL ovf_data: got %0d bytes (first bad index %0d) expected %0d bytes", rx_q.size() - base, fd, exp_q.size());
        end
        vec++;
        if (o_fc !== 12'd0) begin
            miscmp++;
            $display("FAIL ovf_fc_drain: got %0d expected 0", o_fc);
        end
    endtask

    task automatic test_full_wrap();
        bq_t a, b;
        int base, fd;
        bit ok;
        sel = 1'b1;
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = rx_q.size();
        exp_q.delete();
        a = rand_frame(20);
        b = rand_frame(16);
        expect_frame(b);
        exp_dc_small++;
        send_frame(a, -1);
        send_frame(b, -1);
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (o_fc !== 12'd1 || o_dc !== 16'(exp_dc_small)) begin
            miscmp++;
            $display("FAIL wrap_status: got fc=%0d dc=%0d expected fc=1 dc=%0d", o_fc, o_dc, exp_dc_small);
        end
        rdy_fixed = 1'b1;
        wait_rx(base + 16, 100, ok);
        fd = first_diff(base);
        vec++;
        if (!ok || fd != -1) begin
            miscmp++;
            $display("FAIL wrap_data: got %0d bytes (first bad index %0d) expected %0d bytes", rx_q.size() - base, fd, exp_q.size());
        end
        vec++;
        if (o_fc !== 12'd0) begin
            miscmp++;
            $display("FAIL wrap_fc_drain: got %0d expected 0", o_fc);
        end
    endtask

    task automatic test_reset_mid();
        bq_t a, c;
        int base, fd;
        bit ok;
        sel = 1'b0;
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = rx_q.size();
        a = rand_frame(20);
        send_frame(a, -1);
        rdy_fixed = 1'b1;
        wait_rx(base + 10, 100, ok);
        rdy_fixed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vec++;
            if ({o_sready, o_valid, o_last, o_user, o_dp, o_data, o_fc, o_dc} !== '0) begin
                miscmp++;
                $display("FAIL midreset_outputs dut%0d: got rdy=%b vld=%b last=%b dp=%b data=%h fc=%0d dc=%0d expected all zero",
                         s, o_sready, o_valid, o_last, o_dp, o_data, o_fc, o_dc);
            end
        end
        sel = 1'b0;
        exp_dc_big = 0;
        exp_dc_small = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        base = rx_q.size();
        exp_q.delete();
        c = rand_frame(8);
        expect_frame(c);
        rdy_fixed = 1'b1;
        send_frame(c, -1);
        wait_rx(base + 8, 100, ok);
        fd = first_diff(base);
        vec++;
        if (!ok || fd != -1) begin
            miscmp++;
            $display("FAIL midreset_data: got %0d bytes (first bad index %0d) expected %0d bytes", rx_q.size() - base, fd, exp_q.size());
        end
        vec++;
        if (o_fc !== 12'd0 || o_dc !== 16'(exp_dc_big)) begin
            miscmp++;
            $display("FAIL midreset_status: got fc=%0d dc=%0d expected fc=0 dc=%0d", o_fc, o_dc, exp_dc_big);
        end
    endtask

    initial begin
        reset     = 1'b0;
        sel       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_user   = 1'b0;
        rdy_fixed = 1'b0;
        rand_rdy  = 1'b0;
        test_reset();
        test_single_frame();
        test_bad_frame();
        test_back_to_back();
        test_overflow();
        test_full_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
